hazard_unit: RTL
================

# hazard_unit

Pipeline hazard detector and forwarding-select generator for the five-stage MIPS core. It sits beside the ID-stage control decoder and drives that decoder's hazard input. It keeps a shadow record of in-flight destination registers in EX, MEM and WB, stalls ID on load-use and branch-operand hazards, and produces registered EX-stage forwarding selects. On the terminate instruction it drains the pipeline and then holds it.

## Interface
- `REG_W`, default 5: register-index width.
- `DRAIN_CYC`, default 3: cycles between accepting terminate and asserting `halted`.
- `clk` in 1: clock. One clock domain.
- `rst` in 1: reset. Synchronous, active-high.
- `id_valid` in 1: ID stage holds a real instruction.
- `id_op` in 6: ID opcode field.
- `id_funct` in 6: ID funct field.
- `id_rs` in REG_W: ID rs field.
- `id_rt` in REG_W: ID rt field.
- `id_rd` in REG_W: ID rd field.
- `harzard` out 1: combinational stall. Freezes PC and IF/ID; the decoder zeroes its controls.
- `fwd_a_sel` out 2: registered, valid in EX. 0 = regfile, 1 = EX/MEM result, 2 = MEM/WB result.
- `fwd_b_sel` out 2: same encoding, for the rt operand.
- `halted` out 1: pipeline fully drained after terminate.

## Operation
- Opcodes and funct codes come from the shared constants file.
- Destination decode for the ID instruction:
  - R-type with ADD/ADDU/SUB/SUBU/AND/NOR/OR/XOR/SLL/SLLV/SRL/SRLV/SRA/SRAV/SLT: writes rd.
  - LW/ADDI/ADDIU/ANDI/ORI/XORI: writes rt. LW also sets is_load.
  - SW/BEQ/BNE/J/JAL funct/terminate/unknown: no write.
  - Destination 0 is always treated as no write.
- Source decode:
  - R-type reads rs and rt. SLL/SRL/SRA read rt only.
  - I-type ALU ops and LW read rs.
  - SW/BEQ/BNE read rs and rt.
  - J reads nothing.
- Shadow pipeline: three entries EX, MEM, WB, each {valid, dest, is_load}.
  - Every cycle: WB←MEM, MEM←EX.
  - EX←decoded ID instruction, or a bubble (valid=0) when `harzard` is high or `id_valid` is 0.
- Stall conditions. A match means valid, dest≠0, and dest equals a source the ID instruction reads.
  - Load-use: the EX entry is a load and matches.
  - Branch in ID: the EX entry matches (any type), or the MEM entry is a load and matches.
- Forwarding, computed as the ID instruction moves to EX and registered:
  - `fwd_a_sel` = 1 if the current EX entry matches rs, else 2 if the current MEM entry matches rs, else 0. The newer entry wins.
  - `fwd_b_sel` uses rt with the same rule.
  - Bubbles and stalls load 0.
- Terminate FSM, states RUN/DRAIN/HALT:
  - RUN→DRAIN when `id_valid`, op=6'b111111, funct=6'b111111, and no stall. Counter loads DRAIN_CYC.
  - DRAIN: `harzard`=1; the counter decrements each cycle. At 0, go to HALT.
  - HALT: `harzard`=1, `halted`=1. Exits only on `rst`.

## Timing
- Reset values: all shadow entries invalid, `fwd_*_sel`=0, state RUN, counter 0, `halted`=0. This gives `harzard`=0 in the cycle after reset.
- `harzard` is combinational, the same cycle the ID fields are presented. Stall latency is 0.
- Load-use costs 1 bubble.
- Branch after an ALU producer costs 1 bubble.
- Branch immediately after a load costs 2 bubbles.
- `fwd_*_sel` change only on `clk` rising edges.
- Simultaneous load-use and branch conditions produce a single `harzard` level, never more than 2 consecutive bubbles.
- `rst` in DRAIN or HALT returns to RUN next cycle and clears the shadow pipeline.

## Configuration
- `HAZARD_FWD_EN` defined: forwarding as above.
- `HAZARD_FWD_EN` undefined:
  - `fwd_*_sel` tied to 0.
  - Any matching source against a valid EX or MEM entry stalls, regardless of type.
  - A WB match does not stall; the register file writes first and reads second.

## Structure
- The constants file gains the forwarding-select encodings `FWD_REG`/`FWD_EXMEM`/`FWD_MEMWB`, the terminate op/funct, and the FSM state encodings.
- One sub-module, `reg_use_decode`: combinational. Maps op/funct/rs/rt/rd to dest, has_dest, is_load, reads_rs, reads_rt and is_branch.

## Test plan
- LW $2 then ADD $3,$2,$4 → `harzard`=1 for exactly 1 cycle; ADD reaches EX with `fwd_a_sel`=2.
- ADDI $5,$0,1 then SUB $6,$5,$5 → no stall; `fwd_a_sel`=`fwd_b_sel`=1.
- LW $7 then BEQ $7,$0 → `harzard` high 2 consecutive cycles, then low.
- ADD $0,$1,$1 then OR $8,$0,$0 → no stall; sels 0.
- Terminate (0xFC00003F) → `harzard` stays 1; `halted`=1 on the 4th cycle after acceptance with DRAIN_CYC=3. `rst` during DRAIN → `halted`=0 and `harzard`=0 next cycle.
- Repeat the ADDI/SUB case without `HAZARD_FWD_EN` → 2 stall cycles, sels remain 0.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared constants for the hazard unit: MIPS opcode/funct fields, the
// terminate instruction, forwarding-select encodings and FSM states.
package hazard_unit_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;

  // Terminate instruction (0xFC00003F)
  localparam logic [5:0] OP_TERM = 6'h3F;
  localparam logic [5:0] F_TERM  = 6'h3F;

  // EX-stage operand source selects
  localparam logic [1:0] FWD_REG   = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_unit_reg_use_decode.sv
// reg_use_decode: combinational register-usage decode of the ID instruction.
// Reports which register it writes (index 0 never counts as a write), whether
// it is a load, which source fields it reads and whether it is a branch.
module reg_use_decode
  import hazard_unit_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic [REG_W-1:0] rt,
  input  logic [REG_W-1:0] rd,
  output logic [REG_W-1:0] dest,
  output logic             has_dest,
  output logic             is_load,
  output logic             reads_rs,
  output logic             reads_rt,
  output logic             is_branch
);

  // Opcode/funct lookup of destination and source usage.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    dest      = rd;
    has_dest  = 1'b0;
    is_load   = 1'b0;
    reads_rs  = 1'b0;
    reads_rt  = 1'b0;
    is_branch = 1'b0;
    case (op)
      OP_RTYPE: begin
        reads_rs = 1'b1;
        reads_rt = 1'b1;
        case (funct)
          F_SLL, F_SRL, F_SRA: begin
            reads_rs = 1'b0;
            has_dest = 1'b1;
          end
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_NOR, F_OR, F_XOR,
          F_SLLV, F_SRLV, F_SRAV, F_SLT: has_dest = 1'b1;
          default: ;
        endcase
      end
      OP_LW: begin
        dest     = rt;
        has_dest = 1'b1;
        is_load  = 1'b1;
        reads_rs = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: begin
        dest     = rt;
        has_dest = 1'b1;
        reads_rs = 1'b1;
      end
      OP_SW: begin
        reads_rs = 1'b1;
        reads_rt = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        reads_rs  = 1'b1;
        reads_rt  = 1'b1;
        is_branch = 1'b1;
      end
      OP_J, OP_JAL, OP_TERM: ;  // no register dependencies tracked
      default: ;
    endcase
    // $0 is hard-wired, so a write to it never creates a dependency.
    if (dest == '0) begin
      has_dest = 1'b0;
      is_load  = 1'b0;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: load-use / branch-operand stall generation, registered EX
// forwarding selects and terminate drain/halt control for the 5-stage core.
// Build option: define HAZARD_FWD_EN to enable forwarding; without it the
// selects are tied to the register file and every EX/MEM dependency stalls.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int REG_W     = 5,
  parameter int DRAIN_CYC = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [5:0]       id_op,
  input  logic [5:0]       id_funct,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  output logic             harzard,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             halted
);

  localparam int CNT_W = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             is_load;
  } shadow_t;

  logic [REG_W-1:0] dec_dest;
  logic             dec_has_dest, dec_is_load, dec_reads_rs, dec_reads_rt, dec_is_branch;

  shadow_t          ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halted_q, halted_d;

  logic ex_rs_hit, ex_rt_hit, mem_rs_hit, mem_rt_hit, ex_hit, mem_hit;
  logic data_stall, accept, is_term;

  reg_use_decode #(.REG_W(REG_W)) u_decode (
    .op        (id_op),
    .funct     (id_funct),
    .rt        (id_rt),
    .rd        (id_rd),
    .dest      (dec_dest),
    .has_dest  (dec_has_dest),
    .is_load   (dec_is_load),
    .reads_rs  (dec_reads_rs),
    .reads_rt  (dec_reads_rt),
    .is_branch (dec_is_branch)
  );

  // Compare in-flight destinations against the operands ID reads and stall.
  always_comb begin
    ex_rs_hit  = id_valid & dec_reads_rs & ex_q.valid  & (ex_q.dest  != '0) & (ex_q.dest  == id_rs);
    ex_rt_hit  = id_valid & dec_reads_rt & ex_q.valid  & (ex_q.dest  != '0) & (ex_q.dest  == id_rt);
    mem_rs_hit = id_valid & dec_reads_rs & mem_q.valid & (mem_q.dest != '0) & (mem_q.dest == id_rs);
    mem_rt_hit = id_valid & dec_reads_rt & mem_q.valid & (mem_q.dest != '0) & (mem_q.dest == id_rt);
    ex_hit     = ex_rs_hit  | ex_rt_hit;
    mem_hit    = mem_rs_hit | mem_rt_hit;
`ifdef HAZARD_FWD_EN
    // A load in EX has no result yet; a branch resolves in ID so it also
    // needs an ALU result from EX or load data that is still in MEM.
    data_stall = (ex_q.is_load & ex_hit)
               | (dec_is_branch & (ex_hit | (mem_q.is_load & mem_hit)));
`else
    data_stall = ex_hit | mem_hit;
`endif
    harzard = (state_q != ST_RUN) | data_stall;
    accept  = id_valid & ~harzard;
    is_term = id_valid & (id_op == OP_TERM) & (id_funct == F_TERM);
  end

  // Shadow pipeline advance and terminate drain/halt sequencing.
  always_comb begin
    ex_d = '0;
    if (accept) begin
      ex_d.valid   = dec_has_dest;
      ex_d.dest    = dec_dest;
      ex_d.is_load = dec_is_load;
    end
    mem_d    = ex_q;
    wb_d     = mem_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    halted_d = halted_q;
    unique case (state_q)
      ST_RUN: begin
        if (accept && is_term) begin
          state_d = ST_DRAIN;
          cnt_d   = CNT_W'(DRAIN_CYC);
        end
      end
      ST_DRAIN: begin
        cnt_d = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
        if (cnt_q <= CNT_W'(1)) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end
      end
      ST_HALT:  halted_d = 1'b1;
      default:  state_d  = ST_RUN;
    endcase
  end

`ifdef HAZARD_FWD_EN
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

  // Operand source for the instruction entering EX; the newer producer wins.
  always_comb begin
    fwd_a_d = FWD_REG;
    fwd_b_d = FWD_REG;
    if (accept) begin
      if (ex_rs_hit)       fwd_a_d = FWD_EXMEM;
      else if (mem_rs_hit) fwd_a_d = FWD_MEMWB;
      if (ex_rt_hit)       fwd_b_d = FWD_EXMEM;
      else if (mem_rt_hit) fwd_b_d = FWD_MEMWB;
    end
  end

  // Forwarding selects are registered so they line up with the EX stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a_q <= FWD_REG;
      fwd_b_q <= FWD_REG;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;
`else
  logic unused_class;
  assign unused_class = ex_q.is_load ^ mem_q.is_load ^ dec_is_branch;
  assign fwd_a_sel    = FWD_REG;
  assign fwd_b_sel    = FWD_REG;
`endif

  // WB is tracked for completeness; the register file resolves WB reads.
  logic unused_wb;
  assign unused_wb = ^wb_q;

  // Shadow entries, FSM state, drain counter and halted flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: the shadow entries are reset, not left to settle: a stale
      // valid bit out of reset would stall ID on a phantom producer.
      ex_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      state_q  <= ST_RUN;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      ex_q     <= ex_d;
      mem_q    <= mem_d;
      wb_q     <= wb_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
    end
  end

  assign halted = halted_q;

endmodule
